// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: conditions the raw pins, deframes 11-bit frames and
// folds E0/F0/E1 prefixes into the 11-bit {toggle, pressed, extended, code} word.
module ps2_key_decoder #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 36000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        parity_err,
  output logic        frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic          clk_filt_q;
  logic [FW-1:0] stab_cnt_q;
  logic [TW-1:0] to_cnt_q;
  state_e        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic          rel_q, ext_q;
  logic [2:0]    skip_q;

  logic          flip_c, fall_c, par_ok_c, timeout_c;

  // Filtered clock flips on the FILTER_LEN-th consecutive differing sample
  assign flip_c    = (clk_sync_q != clk_filt_q) && (stab_cnt_q == FW'(FILTER_LEN - 1));
  assign fall_c    = flip_c && clk_filt_q;
  assign par_ok_c  = ^{shift_q, par_q};
  assign timeout_c = (state_q != IDLE) && !fall_c && (to_cnt_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      clk_filt_q <= 1'b1;
      stab_cnt_q <= '0;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_data;
      dat_sync_q <= dat_meta_q;
      if (clk_sync_q == clk_filt_q) begin
        stab_cnt_q <= '0;
      end else if (flip_c) begin
        clk_filt_q <= clk_sync_q;
        stab_cnt_q <= '0;
      end else begin
        stab_cnt_q <= stab_cnt_q + FW'(1);
      end
    end
  end

  // Frame FSM and key-event assembly; one transition per filtered falling edge
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      rel_q      <= 1'b0;
      ext_q      <= 1'b0;
      skip_q     <= '0;
      to_cnt_q   <= '0;
      ps2_key    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      if (state_q == IDLE || fall_c) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + TW'(1);
      end

      if (timeout_c) begin
        state_q   <= IDLE;
        frame_err <= 1'b1;
        bit_cnt_q <= '0;
        rel_q     <= 1'b0;
        ext_q     <= 1'b0;
        skip_q    <= '0;
      end else if (fall_c) begin
        unique case (state_q)
          IDLE: begin
            if (!dat_sync_q) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
          DATA: begin
            shift_q   <= {dat_sync_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= PARITY;
            end
          end
          PARITY: begin
            par_q   <= dat_sync_q;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (!dat_sync_q) begin
              frame_err <= 1'b1;
              rel_q     <= 1'b0;
              ext_q     <= 1'b0;
              skip_q    <= '0;
            end else if (!par_ok_c) begin
              parity_err <= 1'b1;
              rel_q      <= 1'b0;
              ext_q      <= 1'b0;
              skip_q     <= '0;
            end else if (skip_q != 3'd0) begin
              skip_q <= skip_q - 3'd1;
            end else begin
              // Pause (E1) is followed by 7 bytes that carry no usable event
              unique case (shift_q)
                8'hE1:   skip_q <= 3'd7;
                8'hE0:   ext_q  <= 1'b1;
                8'hF0:   rel_q  <= 1'b1;
                default: begin
                  ps2_key <= {~ps2_key[10], ~rel_q, ext_q, shift_q};
                  rel_q   <= 1'b0;
                  ext_q   <= 1'b0;
                end
              endcase
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
